// File: rtl/mem_arbiter_pkg.sv
// Shared types for the memory arbiter: FSM states, grant ids, default widths.
// Round-robin class arbitration is enabled by defining MEM_ARBITER_RR_EN.
package mem_arbiter_pkg;

    localparam int ARCH_BITS_DEF = 32;
    localparam int LINE_BITS_DEF = 128;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_RESP = 2'd2
    } state_e;

    typedef enum logic [1:0] {
        GNT_IC  = 2'd0,
        GNT_DCR = 2'd1,
        GNT_DCW = 2'd2
    } gnt_e;

    // Round-robin pointer values: which class is preferred on the next grant.
    localparam logic PTR_DATA = 1'b0;
    localparam logic PTR_INST = 1'b1;

endpackage

// File: rtl/mem_arb_pick.sv
// Combinational grant selection among iCache read, dCache read and dCache write.
// MEM_ARBITER_RR_EN selects round-robin between iCache and dCache classes.
module mem_arb_pick
    import mem_arbiter_pkg::*;
(
    input  logic ic_rd_req_i,
    input  logic dc_rd_req_i,
    input  logic dc_wr_req_i,
`ifdef MEM_ARBITER_RR_EN
    input  logic rr_ptr_i,
`endif
    output logic gnt_vld_o,
    output gnt_e gnt_id_o
);

    logic dc_any;
    gnt_e dc_id;

    // Write-back always beats refill so a dirty victim leaves before its replacement arrives.
    assign dc_any = dc_rd_req_i | dc_wr_req_i;
    assign dc_id  = dc_wr_req_i ? GNT_DCW : GNT_DCR;

    always_comb begin
        gnt_vld_o = ic_rd_req_i | dc_any;
        gnt_id_o  = GNT_IC;
`ifdef MEM_ARBITER_RR_EN
        if (dc_any && (rr_ptr_i == PTR_DATA || !ic_rd_req_i))
            gnt_id_o = dc_id;
`else
        if (dc_any)
            gnt_id_o = dc_id;
`endif
    end

endmodule

// File: rtl/mem_arbiter.sv
// Single-outstanding memory arbiter for iCache/dCache line traffic (IDLE->BUSY->RESP).
// Define MEM_ARBITER_RR_EN for round-robin between iCache and dCache classes.
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int ARCH_BITS = ARCH_BITS_DEF,
    parameter int LINE_BITS = LINE_BITS_DEF
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 ic_rd_req,
    input  logic [ARCH_BITS-1:0] ic_rd_addr,
    output logic [LINE_BITS-1:0] ic_rd_data,
    output logic                 ic_rd_valid,
    input  logic                 dc_rd_req,
    input  logic [ARCH_BITS-1:0] dc_rd_addr,
    output logic [LINE_BITS-1:0] dc_rd_data,
    output logic                 dc_rd_valid,
    input  logic                 dc_wr_req,
    input  logic [ARCH_BITS-1:0] dc_wr_addr,
    input  logic [LINE_BITS-1:0] dc_wr_line,
    output logic                 dc_wr_done,
    output logic                 mem_req,
    output logic                 mem_we,
    output logic [ARCH_BITS-1:0] mem_addr,
    output logic [LINE_BITS-1:0] mem_wdata,
    input  logic [LINE_BITS-1:0] mem_rdata,
    input  logic                 mem_ready
);

    state_e               state_q;
    gnt_e                 gnt_q;
    logic                 mem_req_q, mem_we_q;
    logic [ARCH_BITS-1:0] mem_addr_q;
    logic [LINE_BITS-1:0] mem_wdata_q, rsp_q;
    logic                 ic_vld_q, dcr_vld_q, dcw_done_q;

    logic                 pick_vld;
    gnt_e                 pick_id;
    logic [ARCH_BITS-1:0] addr_d;

`ifdef MEM_ARBITER_RR_EN
    logic rr_ptr_q;
`endif

    mem_arb_pick u_pick (
        .ic_rd_req_i (ic_rd_req),
        .dc_rd_req_i (dc_rd_req),
        .dc_wr_req_i (dc_wr_req),
`ifdef MEM_ARBITER_RR_EN
        .rr_ptr_i    (rr_ptr_q),
`endif
        .gnt_vld_o   (pick_vld),
        .gnt_id_o    (pick_id)
    );

    always_comb begin
        addr_d = ic_rd_addr;
        if (pick_id == GNT_DCR) addr_d = dc_rd_addr;
        if (pick_id == GNT_DCW) addr_d = dc_wr_addr;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            gnt_q       <= GNT_IC;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            rsp_q       <= '0;
            ic_vld_q    <= 1'b0;
            dcr_vld_q   <= 1'b0;
            dcw_done_q  <= 1'b0;
`ifdef MEM_ARBITER_RR_EN
            rr_ptr_q    <= PTR_DATA;
`endif
        end else begin
            ic_vld_q   <= 1'b0;
            dcr_vld_q  <= 1'b0;
            dcw_done_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (pick_vld) begin
                        state_q    <= ST_BUSY;
                        gnt_q      <= pick_id;
                        mem_req_q  <= 1'b1;
                        mem_we_q   <= (pick_id == GNT_DCW);
                        mem_addr_q <= addr_d;
                        if (pick_id == GNT_DCW) mem_wdata_q <= dc_wr_line;
`ifdef MEM_ARBITER_RR_EN
                        rr_ptr_q   <= (pick_id == GNT_IC) ? PTR_DATA : PTR_INST;
`endif
                    end
                end
                ST_BUSY: begin
                    if (mem_ready) begin
                        state_q   <= ST_RESP;
                        mem_req_q <= 1'b0;
                        // Writes leave the last read line visible to both caches.
                        if (!mem_we_q) rsp_q <= mem_rdata;
                        ic_vld_q   <= (gnt_q == GNT_IC);
                        dcr_vld_q  <= (gnt_q == GNT_DCR);
                        dcw_done_q <= (gnt_q == GNT_DCW);
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign mem_req     = mem_req_q;
    assign mem_we      = mem_we_q;
    assign mem_addr    = mem_addr_q;
    assign mem_wdata   = mem_wdata_q;
    assign ic_rd_data  = rsp_q;
    assign dc_rd_data  = rsp_q;
    assign ic_rd_valid = ic_vld_q;
    assign dc_rd_valid = dcr_vld_q;
    assign dc_wr_done  = dcw_done_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter; expectations follow MEM_ARBITER_RR_EN when defined.
module tb_mem_arbiter;

    localparam int AW = 32;
    localparam int LW = 128;

    logic          clk = 1'b0;
    logic          rst;
    logic          ic_rd_req, dc_rd_req, dc_wr_req, mem_ready;
    logic [AW-1:0] ic_rd_addr, dc_rd_addr, dc_wr_addr;
    logic [LW-1:0] dc_wr_line, mem_rdata;
    logic [LW-1:0] ic_rd_data, dc_rd_data, mem_wdata;
    logic          ic_rd_valid, dc_rd_valid, dc_wr_done;
    logic          mem_req, mem_we;
    logic [AW-1:0] mem_addr;
    logic [2:0]    pls;

    int vectors = 0;
    int errors  = 0;

    localparam logic [LW-1:0] LINE_A5  = {16{8'hA5}};
    localparam logic [LW-1:0] LINE_MIN = 128'h0123_4567_89ab_cdef_0011_2233_4455_6677;
    localparam logic [LW-1:0] LINE_RD  = 128'hbeef_0000_1111_2222_3333_4444_5555_6666;
    localparam logic [LW-1:0] LINE_SP  = 128'h7777_8888_9999_aaaa_bbbb_cccc_dddd_eeee;

    always #5 clk = ~clk;

    assign pls = {dc_wr_done, dc_rd_valid, ic_rd_valid};

    mem_arbiter #(.ARCH_BITS(AW), .LINE_BITS(LW)) dut (
        .clk(clk), .rst(rst),
        .ic_rd_req(ic_rd_req), .ic_rd_addr(ic_rd_addr), .ic_rd_data(ic_rd_data), .ic_rd_valid(ic_rd_valid),
        .dc_rd_req(dc_rd_req), .dc_rd_addr(dc_rd_addr), .dc_rd_data(dc_rd_data), .dc_rd_valid(dc_rd_valid),
        .dc_wr_req(dc_wr_req), .dc_wr_addr(dc_wr_addr), .dc_wr_line(dc_wr_line), .dc_wr_done(dc_wr_done),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_ready(mem_ready)
    );

    // Returns the number of negedges until mem_req is seen, or -1 after 20.
    task automatic wait_req(output int cyc);
        cyc = -1;
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            if (mem_req) begin
                cyc = i;
                break;
            end
        end
    endtask

    // Entered at the negedge of the first BUSY cycle; raises mem_ready in the
    // lat-th BUSY cycle and returns at the negedge of the response cycle.
    task automatic mem_respond(input int lat, input logic [LW-1:0] rd,
                               output logic [2:0] early, output logic [2:0] p);
        early = 3'b000;
        for (int i = 1; i <= lat; i++) begin
            early |= pls;
            if (i == lat) begin
                mem_ready = 1'b1;
                mem_rdata = rd;
            end
            @(negedge clk);
            mem_ready = 1'b0;
        end
        p = pls;
    endtask

    task automatic test_reset();
        int bad;
        rst = 1'b1;
        ic_rd_req = 0; dc_rd_req = 0; dc_wr_req = 0; mem_ready = 0;
        ic_rd_addr = '0; dc_rd_addr = '0; dc_wr_addr = '0; dc_wr_line = '0; mem_rdata = '0;
        repeat (3) @(negedge clk);
        vectors++; if (mem_req !== 1'b0) begin errors++; $display("FAIL reset_mem_req: got %b want 0", mem_req); end
        vectors++; if (mem_we !== 1'b0) begin errors++; $display("FAIL reset_mem_we: got %b want 0", mem_we); end
        vectors++; if (mem_addr !== '0) begin errors++; $display("FAIL reset_mem_addr: got %h want 0", mem_addr); end
        vectors++; if (mem_wdata !== '0) begin errors++; $display("FAIL reset_mem_wdata: got %h want 0", mem_wdata); end
        vectors++; if (pls !== 3'b000) begin errors++; $display("FAIL reset_pulses: got %b want 000", pls); end
        vectors++; if (ic_rd_data !== '0 || dc_rd_data !== '0) begin errors++; $display("FAIL reset_rsp: got %h/%h want 0", ic_rd_data, dc_rd_data); end
        rst = 1'b0;
        bad = 0;
        repeat (3) begin @(negedge clk); if (mem_req !== 1'b0) bad++; end
        vectors++; if (bad != 0) begin errors++; $display("FAIL idle_no_req: got %0d busy cycles want 0", bad); end
    endtask

    task automatic test_ic_read();
        int c; logic [2:0] e, p;
        ic_rd_addr = 32'h1000; ic_rd_req = 1'b1;
        wait_req(c);
        vectors++; if (c != 1) begin errors++; $display("FAIL ic_grant_delay: got %0d want 1", c); end
        vectors++; if (mem_we !== 1'b0 || mem_addr !== 32'h1000) begin errors++; $display("FAIL ic_mem_cmd: got we=%b addr=%h want we=0 addr=1000", mem_we, mem_addr); end
        // Grant cycle + 4 BUSY cycles + RESP: pulse is the 6th cycle counting the grant.
        mem_respond(4, LINE_A5, e, p);
        ic_rd_req = 1'b0;
        vectors++; if (e !== 3'b000) begin errors++; $display("FAIL ic_early_pulse: got %b want 000", e); end
        vectors++; if (p !== 3'b001) begin errors++; $display("FAIL ic_pulse: got %b want 001", p); end
        vectors++; if (ic_rd_data !== LINE_A5 || dc_rd_data !== LINE_A5) begin errors++; $display("FAIL ic_data: got %h/%h want %h", ic_rd_data, dc_rd_data, LINE_A5); end
        @(negedge clk);
        vectors++; if (pls !== 3'b000 || mem_req !== 1'b0) begin errors++; $display("FAIL ic_one_pulse: got p=%b req=%b want 000/0", pls, mem_req); end
    endtask

    task automatic test_min_latency();
        int c; logic [2:0] e, p;
        dc_rd_addr = 32'h40; dc_rd_req = 1'b1;
        wait_req(c);
        vectors++; if (c != 1 || mem_addr !== 32'h40) begin errors++; $display("FAIL min_grant: got c=%0d addr=%h want 1/40", c, mem_addr); end
        mem_respond(1, LINE_MIN, e, p);
        dc_rd_req = 1'b0;
        vectors++; if (p !== 3'b010 || e !== 3'b000) begin errors++; $display("FAIL min_pulse: got %b early %b want 010/000", p, e); end
        vectors++; if (dc_rd_data !== LINE_MIN) begin errors++; $display("FAIL min_data: got %h want %h", dc_rd_data, LINE_MIN); end
        @(negedge clk);
    endtask

    task automatic test_wr_over_rd();
        int c; logic [2:0] e, p;
        dc_wr_addr = 32'h8000; dc_wr_line = 128'h1234; dc_wr_req = 1'b1;
        dc_rd_addr = 32'h9000; dc_rd_req = 1'b1;
        wait_req(c);
        vectors++; if (c != 1 || mem_we !== 1'b1 || mem_addr !== 32'h8000) begin errors++; $display("FAIL wr_first: got c=%0d we=%b addr=%h want 1/1/8000", c, mem_we, mem_addr); end
        vectors++; if (mem_wdata !== 128'h1234) begin errors++; $display("FAIL wr_wdata: got %h want 1234", mem_wdata); end
        mem_respond(2, 128'hdead, e, p);
        dc_wr_req = 1'b0;
        vectors++; if (p !== 3'b100 || e !== 3'b000) begin errors++; $display("FAIL wr_done: got %b early %b want 100/000", p, e); end
        vectors++; if (dc_rd_data !== LINE_MIN) begin errors++; $display("FAIL wr_keeps_rsp: got %h want %h", dc_rd_data, LINE_MIN); end
        wait_req(c);
        vectors++; if (c != 2 || mem_we !== 1'b0 || mem_addr !== 32'h9000) begin errors++; $display("FAIL rd_after_wr: got c=%0d we=%b addr=%h want 2/0/9000", c, mem_we, mem_addr); end
        mem_respond(3, LINE_RD, e, p);
        dc_rd_req = 1'b0;
        vectors++; if (p !== 3'b010 || dc_rd_data !== LINE_RD) begin errors++; $display("FAIL rd_after_wr_resp: got %b %h want 010 %h", p, dc_rd_data, LINE_RD); end
        @(negedge clk);
    endtask

    task automatic test_arbitration();
        int c; logic [2:0] e, p;
        logic [AW-1:0] exp_addr;
        rst = 1'b1; @(negedge clk); rst = 1'b0;
        ic_rd_addr = 32'h100; dc_rd_addr = 32'h200;
        ic_rd_req = 1'b1; dc_rd_req = 1'b1;
        for (int k = 0; k < 4; k++) begin
`ifdef MEM_ARBITER_RR_EN
            exp_addr = (k % 2 == 0) ? 32'h200 : 32'h100;
`else
            exp_addr = 32'h200;
`endif
            wait_req(c);
            vectors++; if (c < 0 || mem_addr !== exp_addr) begin errors++; $display("FAIL arb_grant%0d: got c=%0d addr=%h want addr=%h", k, c, mem_addr, exp_addr); end
            mem_respond(1, LINE_SP ^ LW'(k), e, p);
            vectors++; if (p !== ((exp_addr == 32'h200) ? 3'b010 : 3'b001)) begin errors++; $display("FAIL arb_pulse%0d: got %b", k, p); end
        end
        ic_rd_req = 1'b0; dc_rd_req = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    task automatic test_reset_abort();
        int c, bad;
        ic_rd_addr = 32'h2000; ic_rd_req = 1'b1;
        wait_req(c);
        vectors++; if (c != 1 || mem_addr !== 32'h2000) begin errors++; $display("FAIL abort_grant: got c=%0d addr=%h want 1/2000", c, mem_addr); end
        rst = 1'b1; ic_rd_req = 1'b0;
        @(negedge clk);
        vectors++; if (mem_req !== 1'b0 || pls !== 3'b000) begin errors++; $display("FAIL abort_req: got req=%b p=%b want 0/000", mem_req, pls); end
        rst = 1'b0;
        bad = 0;
        repeat (4) begin @(negedge clk); if (mem_req !== 1'b0 || pls !== 3'b000) bad++; end
        vectors++; if (bad != 0) begin errors++; $display("FAIL abort_idle: got %0d active cycles want 0", bad); end
    endtask

    task automatic test_spurious_and_latch();
        int c, bad; logic [2:0] e, p;
        mem_ready = 1'b1; mem_rdata = {LW{1'b1}};
        @(negedge clk);
        mem_ready = 1'b0;
        bad = 0;
        repeat (2) begin @(negedge clk); if (pls !== 3'b000 || mem_req !== 1'b0) bad++; end
        vectors++; if (bad != 0 || ic_rd_data !== '0) begin errors++; $display("FAIL spurious_ready: got %0d bad cycles rsp=%h want 0/0", bad, ic_rd_data); end
        ic_rd_addr = 32'h3000; ic_rd_req = 1'b1;
        wait_req(c);
        // Changes after the grant, plus a short ungranted request, must go unnoticed.
        ic_rd_addr = 32'h3F00; dc_rd_addr = 32'h5000; dc_rd_req = 1'b1;
        @(negedge clk);
        dc_rd_req = 1'b0;
        @(negedge clk);
        vectors++; if (c != 1 || mem_addr !== 32'h3000) begin errors++; $display("FAIL latched_addr: got c=%0d addr=%h want 1/3000", c, mem_addr); end
        mem_respond(2, LINE_SP, e, p);
        ic_rd_req = 1'b0;
        vectors++; if (p !== 3'b001 || e !== 3'b000 || ic_rd_data !== LINE_SP) begin errors++; $display("FAIL latched_resp: got %b early %b data %h", p, e, ic_rd_data); end
        bad = 0;
        repeat (4) begin @(negedge clk); if (mem_req !== 1'b0) bad++; end
        vectors++; if (bad != 0) begin errors++; $display("FAIL ignored_req: got %0d busy cycles want 0", bad); end
    endtask

    initial begin
        test_reset();
        test_ic_read();
        test_min_latency();
        test_wr_over_rd();
        test_arbitration();
        test_reset_abort();
        test_spurious_and_latch();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter ARCH_BITS, default 32, address width.
REQ-002 SHALL have parameter LINE_BITS, default 128, memory line width.
REQ-003 clk  input  1  clock; all state updates on posedge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 ic_rd_req  input  1  iCache line-read request, level, held until ic_rd_valid.
REQ-006 ic_rd_addr  input  ARCH_BITS  iCache read address.
REQ-007 ic_rd_data  output  LINE_BITS  line returned to iCache.
REQ-008 ic_rd_valid  output  1  one-cycle pulse, ic_rd_data valid.
REQ-009 dc_rd_req / dc_rd_addr / dc_rd_data / dc_rd_valid: same widths and meaning as REQ-005..008, for dCache refill.
REQ-010 dc_wr_req  input  1  dCache write-back request, level, held until dc_wr_done.
REQ-011 dc_wr_addr  input  ARCH_BITS  write-back address.
REQ-012 dc_wr_line  input  LINE_BITS  write-back data.
REQ-013 dc_wr_done  output  1  one-cycle pulse, write committed.
REQ-014 mem_req  output  1  memory request, held until mem_ready.
REQ-015 mem_we  output  1  1 = write, 0 = read; stable while mem_req.
REQ-016 mem_addr  output  ARCH_BITS  line address; stable while mem_req.
REQ-017 mem_wdata  output  LINE_BITS  write line; stable while mem_req.
REQ-018 mem_rdata  input  LINE_BITS  read line, valid when mem_ready and !mem_we.
REQ-019 mem_ready  input  1  one-cycle completion pulse from memory.

Function
REQ-020 SHALL implement FSM IDLE -> BUSY -> RESP -> IDLE; one memory transaction in flight.
REQ-021 IDLE: with any request pending, SHALL grant one requester, latch its addr (and line, if write) plus 2-bit grant id, and enter BUSY next cycle; no request -> stay IDLE.
REQ-022 BUSY: mem_req=1 with latched mem_we/mem_addr/mem_wdata; on mem_ready SHALL capture mem_rdata into the response register and enter RESP.
REQ-023 RESP: SHALL pulse exactly one of ic_rd_valid, dc_rd_valid, dc_wr_done per grant id, mem_req=0, then IDLE.
REQ-024 ic_rd_data and dc_rd_data SHALL both be driven from the response register; it holds its value until the next read completes.
REQ-025 Grant-to-response latency SHALL be (memory latency + 2) cycles; minimum 3 cycles when mem_ready arrives the first BUSY cycle.
REQ-026 Requests changing while not granted SHALL be ignored; a granted request's inputs SHALL be latched at grant and later changes ignored.
REQ-027 dc_wr_req SHALL always win over dc_rd_req (write-back before refill).
REQ-028 Fixed priority (macro absent): dc_wr > dc_rd > ic_rd.
REQ-029 mem_ready outside BUSY SHALL be ignored.
REQ-030 No requester SHALL be granted twice within one transaction; IDLE is always visited between transactions (back-to-back grant gap = 1 cycle).

Reset
REQ-031 On rst: state IDLE, mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0, all valid/done pulses 0, response register 0, round-robin pointer to data side.
REQ-032 rst asserted in BUSY or RESP SHALL abort the transaction without any valid/done pulse.

Configuration
REQ-033 Macro MEM_ARBITER_RR_EN defined: arbitration between iCache class (ic_rd) and dCache class (dc_wr, dc_rd) SHALL round-robin; a 1-bit pointer flips to the other class after each grant; inside dCache class REQ-027 holds.
REQ-034 Macro absent: REQ-028 fixed priority; pointer logic not compiled.

Structure
REQ-035 Shared package SHALL hold FSM state encoding, grant-id encoding (GNT_IC, GNT_DCR, GNT_DCW) and ARCH_BITS/LINE_BITS defaults.
REQ-036 One sub-module mem_arb_pick SHALL hold the combinational grant selection (priority/round-robin); FSM and registers stay in mem_arbiter.

Verification
REQ-037 ic_rd_req, addr 0x1000, memory returns 0xA5.. after 4 cycles -> mem_req/mem_we=0 addr 0x1000, ic_rd_valid one pulse 6 cycles after grant, ic_rd_data=0xA5...
REQ-038 dc_wr_req (0x8000, line 0x1234) and dc_rd_req (0x9000) same cycle -> write granted first, dc_wr_done, then read at 0x9000, dc_rd_valid.
REQ-039 ic_rd and dc_rd continuously asserted: fixed build -> dc_rd granted every time; MEM_ARBITER_RR_EN build -> grants alternate dc, ic, dc, ic.
REQ-040 rst asserted in BUSY for 0x2000 read -> mem_req=0 next cycle, no ic_rd_valid, stays IDLE with no requests.
REQ-041 Spurious mem_ready in IDLE, then address change of granted request during BUSY -> no pulse generated; mem_addr holds originally latched value.
